// File: rtl/tc_file_rom_arbiter.sv
// Round-robin arbiter sharing one registered-read TC file-ROM port among NUM_REQ requesters.
// Optional macro FILEROM_SIZE_CACHE_EN: cache the file byte count (all-ones address) after reset.
module tc_file_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_data,
  output logic                      rom_rst,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_address,
  input  logic [DATA_W-1:0]         rom_out
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

`ifdef FILEROM_SIZE_CACHE_EN
  localparam logic [ADDR_W-1:0] SIZE_ADDR = '1;
  typedef enum logic [2:0] {IDLE, ISSUE, RESP, INIT_ISSUE, INIT_RESP, LOCAL} state_t;
  localparam state_t RESET_STATE = INIT_ISSUE;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t             state;
  state_t             state_next;
  logic [PTR_W-1:0]   rr_ptr;
  logic [PTR_W-1:0]   gnt_q;
  logic [ADDR_W-1:0]  addr_q;
  logic [ADDR_W-1:0]  last_addr_q;
  logic [PTR_W-1:0]   winner;
  logic [PTR_W-1:0]   rr_next;
  logic [PTR_W-1:0]   idx;
  logic               found;
  logic               accept;
  logic [ADDR_W-1:0]  win_addr;
`ifdef FILEROM_SIZE_CACHE_EN
  logic [DATA_W-1:0]  size_q;
`endif

  assign rom_rst = ~rst_n;

  // First pending requester at or after rr_ptr, wrapping at NUM_REQ-1.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    idx    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PTR_W'((int'(rr_ptr) + i) % NUM_REQ);
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign win_addr = req_addr[int'(winner)*ADDR_W +: ADDR_W];
  assign rr_next  = (winner == PTR_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    req_ready   = '0;
    rsp_valid   = '0;
    rsp_data    = '0;
    rom_en      = 1'b0;
    rom_address = last_addr_q;
    case (state)
      IDLE: begin
        if (found) begin
          accept            = 1'b1;
          req_ready[winner] = 1'b1;
          state_next        = ISSUE;
`ifdef FILEROM_SIZE_CACHE_EN
          if (win_addr == SIZE_ADDR) state_next = LOCAL;
`endif
        end
      end
      ISSUE: begin
        rom_en      = 1'b1;
        rom_address = addr_q;
        state_next  = RESP;
      end
      RESP: begin
        rsp_valid[gnt_q] = 1'b1;
        rsp_data         = rom_out;
        state_next       = IDLE;
      end
`ifdef FILEROM_SIZE_CACHE_EN
      INIT_ISSUE: begin
        rom_en      = 1'b1;
        rom_address = SIZE_ADDR;
        state_next  = INIT_RESP;
      end
      INIT_RESP: state_next = IDLE;
      LOCAL: begin
        rsp_valid[gnt_q] = 1'b1;
        rsp_data         = size_q;
        state_next       = IDLE;
      end
`endif
      default: state_next = RESET_STATE;
    endcase
    // Outputs are forced quiet for the whole time reset is held, not just after the edge.
    if (!rst_n) begin
      accept      = 1'b0;
      req_ready   = '0;
      rsp_valid   = '0;
      rsp_data    = '0;
      rom_en      = 1'b0;
      rom_address = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= RESET_STATE;
      rr_ptr      <= '0;
      addr_q      <= '0;
      gnt_q       <= '0;
      last_addr_q <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q <= win_addr;
        gnt_q  <= winner;
        rr_ptr <= rr_next;
      end
      if (rom_en) last_addr_q <= rom_address;
    end
  end

`ifdef FILEROM_SIZE_CACHE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                  size_q <= '0;
    else if (state == INIT_RESP) size_q <= rom_out;
  end
`endif

endmodule

// File: tb/tb_tc_file_rom_arbiter.sv
// Self-checking bench for tc_file_rom_arbiter: behavioural ROM plus a cycle-timeline scoreboard.
// Honours FILEROM_SIZE_CACHE_EN the same way the design does.
module tb_tc_file_rom_arbiter;

  localparam int N     = 4;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int DEPTH = 512;
  localparam int VW    = 2*N + 1 + AW + DW + 1;
  localparam logic [AW-1:0] ONES       = '1;
  localparam logic [DW-1:0] FILE_BYTES = 64'd755;
`ifdef FILEROM_SIZE_CACHE_EN
  localparam int INIT_CYCLES = 2;
`else
  localparam int INIT_CYCLES = 0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            rom_rst;
  logic            rom_en;
  logic [AW-1:0]   rom_address;
  logic [DW-1:0]   rom_out = '0;

  int checks = 0;
  int failures = 0;

  tc_file_rom_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rom_rst(rom_rst), .rom_en(rom_en), .rom_address(rom_address), .rom_out(rom_out)
  );

  always #5 clk = ~clk;

  // Behavioural file ROM: little-endian 8-byte word, all-ones address returns the byte count.
  logic [7:0] mem [256];

  function automatic logic [DW-1:0] rom_word(input logic [AW-1:0] a);
    logic [DW-1:0] w;
    w = '0;
    if (a == ONES) return FILE_BYTES;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = mem[8'(a + AW'(k))];
    return w;
  endfunction

  always @(posedge clk) begin
    if (rom_rst)     rom_out <= '0;
    else if (rom_en) rom_out <= rom_word(rom_address);
  end

  // Scoreboard: what each cycle (counted from reset release) must show.
  int            cyc;
  int            busy_until;
  int            ptr;
  logic [AW-1:0] last_addr;
  logic [N-1:0]  s_valid [DEPTH];
  logic [DW-1:0] s_data  [DEPTH];
  logic          s_en    [DEPTH];
  logic [AW-1:0] s_addr  [DEPTH];
  logic [N-1:0]  e_ready;
  logic [N-1:0]  e_valid;
  logic [DW-1:0] e_data;
  logic          e_en;
  logic [AW-1:0] e_addr;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      s_valid[i] = '0; s_data[i] = '0; s_en[i] = 1'b0; s_addr[i] = '0;
    end
    cyc = 0; ptr = 0; busy_until = 0; last_addr = '0;
`ifdef FILEROM_SIZE_CACHE_EN
    s_en[0] = 1'b1; s_addr[0] = ONES; busy_until = 2;
`endif
  endtask

  // Drive one cycle's inputs and derive that cycle's expected outputs.
  task automatic tick(input logic [N-1:0] v, input logic [N*AW-1:0] a);
    @(negedge clk);
    req_valid = v;
    req_addr  = a;
    #1;
    e_ready = '0;
    e_valid = s_valid[cyc];
    e_data  = s_data[cyc];
    e_en    = s_en[cyc];
    if (s_en[cyc]) last_addr = s_addr[cyc];
    e_addr = last_addr;
    if (cyc >= busy_until) begin
      for (int i = 0; i < N; i++) begin
        int id;
        logic [AW-1:0] ad;
        id = (ptr + i) % N;
        if (v[id]) begin
          ad = a[id*AW +: AW];
          e_ready[id] = 1'b1;
          ptr = (id + 1) % N;
`ifdef FILEROM_SIZE_CACHE_EN
          if (ad == ONES) begin
            s_valid[cyc+1][id] = 1'b1;
            s_data[cyc+1] = FILE_BYTES;
            busy_until = cyc + 2;
          end else
`endif
          begin
            s_en[cyc+1] = 1'b1;
            s_addr[cyc+1] = ad;
            s_valid[cyc+2][id] = 1'b1;
            s_data[cyc+2] = rom_word(ad);
            busy_until = cyc + 3;
          end
          break;
        end
      end
    end
    cyc++;
  endtask

  function automatic logic [VW-1:0] obs_vec();
    return {req_ready, rsp_valid, rom_en, rom_address, (|e_valid) ? rsp_data : 64'd0, rom_rst};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {e_ready, e_valid, e_en, e_addr, e_data, 1'b0};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic settle();
    for (int i = 0; i < INIT_CYCLES; i++) tick('0, '0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = '1;
    req_addr = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    #1;
    if ({req_ready, rsp_valid, rom_en, rom_address, rsp_data, rom_rst} !== {8'h00, 1'b0, 64'h0, 64'h0, 1'b1}) begin
      failures++;
      $display("[TB] FAIL reset_outputs got ready=%b rsp=%b en=%b addr=%h data=%h rom_rst=%b exp all zero, rom_rst=1",
               req_ready, rsp_valid, rom_en, rom_address, rsp_data, rom_rst);
    end
    checks++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    for (int k = 0; k < 3; k++) begin
      tick('0, '0);
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL reset_release cyc=%0d got=%h exp=%h", cyc - 1, obs_vec(), exp_vec());
      end
      checks++;
    end
  endtask

  task automatic test_single();
    logic [N*AW-1:0] a;
    do_reset();
    settle();
    a = '0;
    a[0 +: AW] = 64'h10;
    for (int k = 0; k < 4; k++) begin
      tick((k == 0) ? 4'b0001 : 4'b0000, a);
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL single cyc=%0d got=%h exp=%h", cyc - 1, obs_vec(), exp_vec());
      end
      checks++;
      if (k == 0 && req_ready !== 4'b0001) begin
        failures++;
        $display("[TB] FAIL single_ready got=%b exp=0001", req_ready);
      end
      if (k == 1 && (rom_en !== 1'b1 || rom_address !== 64'h10)) begin
        failures++;
        $display("[TB] FAIL single_issue got en=%b addr=%h exp en=1 addr=10", rom_en, rom_address);
      end
      if (k == 2 && (rsp_valid !== 4'b0001 || rsp_data !== 64'h0807060504030201)) begin
        failures++;
        $display("[TB] FAIL single_rsp got rsp=%b data=%h exp rsp=0001 data=0807060504030201", rsp_valid, rsp_data);
      end
      if (k < 3) checks++;
    end
  endtask

  task automatic test_contention();
    logic [N*AW-1:0] a;
    int g;
    do_reset();
    settle();
    for (int i = 0; i < N; i++) a[i*AW +: AW] = AW'(8 * i + 3);
    g = 0;
    for (int k = 0; k < 16; k++) begin
      tick(4'b1111, a);
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL contention cyc=%0d got=%h exp=%h", cyc - 1, obs_vec(), exp_vec());
      end
      checks++;
      if (req_ready !== 4'b0000 && g < 5) begin
        if (req_ready !== 4'(1 << (g % 4))) begin
          failures++;
          $display("[TB] FAIL contention_order grant#%0d got=%b exp=%b", g, req_ready, 4'(1 << (g % 4)));
        end
        checks++;
        g++;
      end
    end
    if (g < 5) begin
      failures++;
      $display("[TB] FAIL contention_timeout grants=%0d exp=5", g);
    end
    checks++;
  endtask

  task automatic test_fairness();
    logic [N*AW-1:0] a;
    logic [N-1:0] v;
    do_reset();
    settle();
    a = '0;
    a[0 +: AW]  = 64'h40;
    a[AW +: AW] = 64'h50;
    for (int k = 0; k < 7; k++) begin
      v = (k == 0) ? 4'b0010 : 4'b0011;
      if (k > 3) v = 4'b0000;
      tick(v, a);
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL fairness cyc=%0d got=%h exp=%h", cyc - 1, obs_vec(), exp_vec());
      end
      checks++;
      if (k == 3) begin
        if (req_ready !== 4'b0001) begin
          failures++;
          $display("[TB] FAIL fairness_wrap got=%b exp=0001", req_ready);
        end
        checks++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [N*AW-1:0] a;
    do_reset();
    settle();
    a = '0;
    a[2*AW +: AW] = 64'h20;
    a[0 +: AW]    = 64'h30;
    tick(4'b0100, a);
    @(negedge clk);
    rst_n = 1'b0;
    req_valid = 4'b1111;
    #1;
    if ({req_ready, rsp_valid, rom_en, rom_address, rsp_data} !== {8'h00, 1'b0, 64'h0, 64'h0}) begin
      failures++;
      $display("[TB] FAIL reset_mid got ready=%b rsp=%b en=%b addr=%h data=%h exp all zero",
               req_ready, rsp_valid, rom_en, rom_address, rsp_data);
    end
    checks++;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    settle();
    for (int k = 0; k < 5; k++) begin
      tick((k == 0) ? 4'b1111 : 4'b0000, a);
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL reset_mid_after cyc=%0d got=%h exp=%h", cyc - 1, obs_vec(), exp_vec());
      end
      checks++;
      if (k == 0) begin
        if (req_ready !== 4'b0001) begin
          failures++;
          $display("[TB] FAIL reset_mid_ptr got=%b exp=0001", req_ready);
        end
        checks++;
      end
    end
  endtask

  task automatic test_size_read();
    logic [N*AW-1:0] a;
    int t;
    do_reset();
    a = '0;
    a[2*AW +: AW] = ONES;
    t = INIT_CYCLES;
    for (int k = 0; k < INIT_CYCLES + 4; k++) begin
      tick((k == t) ? 4'b0100 : 4'b0000, a);
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL size_read cyc=%0d got=%h exp=%h", cyc - 1, obs_vec(), exp_vec());
      end
      checks++;
`ifdef FILEROM_SIZE_CACHE_EN
      if (k == 0 && (rom_en !== 1'b1 || rom_address !== ONES)) begin
        failures++;
        $display("[TB] FAIL size_init got en=%b addr=%h exp en=1 addr=all-ones", rom_en, rom_address);
      end
      if (k == t + 1 && (rsp_valid !== 4'b0100 || rsp_data !== FILE_BYTES || rom_en !== 1'b0)) begin
        failures++;
        $display("[TB] FAIL size_local got rsp=%b data=%0d en=%b exp rsp=0100 data=755 en=0", rsp_valid, rsp_data, rom_en);
      end
`else
      if (k == t + 1 && (rom_en !== 1'b1 || rom_address !== ONES)) begin
        failures++;
        $display("[TB] FAIL size_issue got en=%b addr=%h exp en=1 addr=all-ones", rom_en, rom_address);
      end
      if (k == t + 2 && (rsp_valid !== 4'b0100 || rsp_data !== FILE_BYTES)) begin
        failures++;
        $display("[TB] FAIL size_rsp got rsp=%b data=%0d exp rsp=0100 data=755", rsp_valid, rsp_data);
      end
`endif
    end
    checks += 2;
  endtask

  task automatic test_random();
    logic [N*AW-1:0] a;
    logic [N-1:0] v;
    do_reset();
    settle();
    for (int k = 0; k < 300; k++) begin
      v = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++)
        a[i*AW +: AW] = ($urandom_range(0, 7) == 0) ? ONES : AW'($urandom_range(0, 255));
      tick(v, a);
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("[TB] FAIL random cyc=%0d got=%h exp=%h", cyc - 1, obs_vec(), exp_vec());
      end
      checks++;
    end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog simulation time limit reached");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 8; i++) mem[16 + i] = 8'(i + 1);
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_reset_mid();
    test_size_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
